// File: rtl/axi_rd_arbiter.sv
// Three-master AXI read-channel arbiter: round-robin address grant, one outstanding
// burst at a time, read data routed back by the held grant, sticky burst-length check.
module axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [2:0][ID_W-1:0]   ARID_M,
   input  logic [2:0][ADDR_W-1:0] ARADDR_M,
   input  logic [2:0][3:0]        ARLEN_M,
   input  logic [2:0][2:0]        ARSIZE_M,
   input  logic [2:0][1:0]        ARBURST_M,
   input  logic [2:0]             ARVALID_M,
   output logic [2:0]             ARREADY_M,
   output logic [2:0][ID_W-1:0]   RID_M,
   output logic [DATA_W-1:0]      RDATA_M,
   output logic [1:0]             RRESP_M,
   output logic                   RLAST_M,
   output logic [2:0]             RVALID_M,
   input  logic [2:0]             RREADY_M,
   output logic [ID_W+1:0]        ARID_S,
   output logic [ADDR_W-1:0]      ARADDR_S,
   output logic [3:0]             ARLEN_S,
   output logic [2:0]             ARSIZE_S,
   output logic [1:0]             ARBURST_S,
   output logic                   ARVALID_S,
   input  logic                   ARREADY_S,
   input  logic [ID_W+1:0]        RID_S,
   input  logic [DATA_W-1:0]      RDATA_S,
   input  logic [1:0]             RRESP_S,
   input  logic                   RLAST_S,
   input  logic                   RVALID_S,
   output logic                   RREADY_S,
   output logic                   ERR_LEN
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state_reg, state_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [1:0] grant_reg, grant_next;
   logic [3:0] len_reg, len_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       err_reg, err_next;

   logic [1:0] pick;
   logic       in_addr;
   logic       in_data;
   logic       rid_hi_unused;

   // Returned-ID upper bits are ignored: data follows the held grant.
   assign rid_hi_unused = ^RID_S[ID_W+1:ID_W];

   assign in_addr = (state_reg == ADDR);
   assign in_data = (state_reg == DATA);

   // First requester strictly after the last-granted master, cyclic 0->1->2->0.
   always_comb begin
      pick = 2'd0;
      case (ptr_reg)
         2'd0:    pick = ARVALID_M[1] ? 2'd1 : (ARVALID_M[2] ? 2'd2 : 2'd0);
         2'd1:    pick = ARVALID_M[2] ? 2'd2 : (ARVALID_M[0] ? 2'd0 : 2'd1);
         default: pick = ARVALID_M[0] ? 2'd0 : (ARVALID_M[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_reg <= IDLE;
         ptr_reg   <= 2'd2;
         grant_reg <= 2'd0;
         len_reg   <= 4'd0;
         cnt_reg   <= 4'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         grant_reg <= grant_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      grant_next = grant_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (|ARVALID_M) begin
               grant_next = pick;
               state_next = ADDR;
            end
         end
         ADDR: begin
            if (ARREADY_S) begin
               len_next   = ARLEN_M[grant_reg];
               cnt_next   = 4'd0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (RVALID_S && RREADY_M[grant_reg]) begin
               cnt_next = cnt_reg + 4'd1;
               // Flag early or missing RLAST; the burst still ends only on RLAST.
               if ((RLAST_S && (cnt_reg != len_reg)) || (!RLAST_S && (cnt_reg == len_reg)))
                  err_next = 1'b1;
               if (RLAST_S) begin
                  state_next = IDLE;
                  ptr_next   = grant_reg;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ARID_S    = {grant_reg, ARID_M[grant_reg]};
   assign ARADDR_S  = ARADDR_M[grant_reg];
   assign ARLEN_S   = ARLEN_M[grant_reg];
   assign ARSIZE_S  = ARSIZE_M[grant_reg];
   assign ARBURST_S = ARBURST_M[grant_reg];
   assign ARVALID_S = in_addr;
   assign RREADY_S  = in_data && RREADY_M[grant_reg];
   assign RDATA_M   = RDATA_S;
   assign RRESP_M   = RRESP_S;
   assign RLAST_M   = RLAST_S;
   assign ERR_LEN   = err_reg;

   for (genvar gi = 0; gi < 3; gi++) begin : g_master
      logic sel;
      assign sel           = (grant_reg == 2'(gi));
      assign ARREADY_M[gi] = in_addr && sel && ARREADY_S;
      assign RVALID_M[gi]  = in_data && sel && RVALID_S;
      assign RID_M[gi]     = (in_data && sel) ? RID_S[ID_W-1:0] : '0;
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR grants and R beats are queued as
// stimulus is driven and popped when the arbiter presents them.
module tb_axi_rd_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;

   logic                   aclk = 1'b0;
   logic                   aresetn;
   logic [2:0][ID_W-1:0]   arid_m;
   logic [2:0][ADDR_W-1:0] araddr_m;
   logic [2:0][3:0]        arlen_m;
   logic [2:0][2:0]        arsize_m;
   logic [2:0][1:0]        arburst_m;
   logic [2:0]             arvalid_m;
   logic [2:0]             arready_m;
   logic [2:0][ID_W-1:0]   rid_m;
   logic [DATA_W-1:0]      rdata_m;
   logic [1:0]             rresp_m;
   logic                   rlast_m;
   logic [2:0]             rvalid_m;
   logic [2:0]             rready_m;
   logic [ID_W+1:0]        arid_s;
   logic [ADDR_W-1:0]      araddr_s;
   logic [3:0]             arlen_s;
   logic [2:0]             arsize_s;
   logic [1:0]             arburst_s;
   logic                   arvalid_s;
   logic                   arready_s;
   logic [ID_W+1:0]        rid_s;
   logic [DATA_W-1:0]      rdata_s;
   logic [1:0]             rresp_s;
   logic                   rlast_s;
   logic                   rvalid_s;
   logic                   rready_s;
   logic                   err_len;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int               m;
      logic [ID_W+1:0]  id;
      logic [ADDR_W-1:0] addr;
      logic [3:0]       len;
   } ar_exp_t;

   typedef struct {
      int                m;
      logic [ID_W-1:0]   rid;
      logic [DATA_W-1:0] data;
      logic              last;
   } r_exp_t;

   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .ACLK(aclk), .ARESETn(aresetn),
      .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m), .ARSIZE_M(arsize_m),
      .ARBURST_M(arburst_m), .ARVALID_M(arvalid_m), .ARREADY_M(arready_m),
      .RID_M(rid_m), .RDATA_M(rdata_m), .RRESP_M(rresp_m), .RLAST_M(rlast_m),
      .RVALID_M(rvalid_m), .RREADY_M(rready_m),
      .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
      .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(arready_s),
      .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s), .RLAST_S(rlast_s),
      .RVALID_S(rvalid_s), .RREADY_S(rready_s), .ERR_LEN(err_len)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] onehot(input int m);
      return 3'(1 << m);
   endfunction

   task automatic clear_inputs();
      arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
      arvalid_m = '0; rready_m = '0; arready_s = 1'b0; rid_s = '0; rdata_s = '0;
      rresp_s = '0; rlast_s = 1'b0; rvalid_s = 1'b0;
   endtask

   task automatic request(input int m, input logic [ID_W-1:0] id,
                          input logic [ADDR_W-1:0] addr, input logic [3:0] len);
      ar_exp_t e;
      arid_m[m] = id; araddr_m[m] = addr; arlen_m[m] = len;
      arsize_m[m] = 3'd2; arburst_m[m] = 2'b01; arvalid_m[m] = 1'b1;
      e.m = m; e.id = {2'(m), id}; e.addr = addr; e.len = len;
      ar_q.push_back(e);
   endtask

   task automatic wait_ar(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge aclk);
         rvalid_s = 1'b0; rlast_s = 1'b0; arready_s = 1'b1;
         #1;
         if (arvalid_s) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic ar_done(input int m);
      @(negedge aclk);
      arready_s = 1'b0;
      arvalid_m[m] = 1'b0;
   endtask

   task automatic beat(input int m, input logic [ID_W-1:0] rid, input logic last,
                       input logic [2:0] rready);
      r_exp_t e;
      @(negedge aclk);
      arready_s = 1'b0;
      rvalid_s = 1'b1; rid_s = {2'(m), rid}; rdata_s = $urandom; rresp_s = 2'b00;
      rlast_s = last; rready_m = rready;
      if (rready[m]) begin
         e.m = m; e.rid = rid; e.data = rdata_s; e.last = last;
         r_q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      clear_inputs();
      arvalid_m = 3'b111;
      repeat (3) @(posedge aclk);
      @(negedge aclk); #1;
      n_checks++;
      if ({arvalid_s, arready_m, rvalid_m, rready_s, err_len} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got arvalid_s=%b arready_m=%b rvalid_m=%b rready_s=%b err_len=%b, expected all 0",
                  arvalid_s, arready_m, rvalid_m, rready_s, err_len);
      end
      arvalid_m = 3'b000;
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      n_checks++;
      if (arvalid_s !== 1'b0 || err_len !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got arvalid_s=%b err_len=%b, expected 0 0", arvalid_s, err_len);
      end
   endtask

   task automatic test_round_robin();
      bit seen; ar_exp_t ea; r_exp_t er;
      @(negedge aclk);
      request(0, 4'h1, 32'h0000_1000, 4'd0);
      request(1, 4'h2, 32'h0000_2000, 4'd0);
      request(2, 4'h3, 32'h0000_3000, 4'd0);
      for (int k = 0; k < 3; k++) begin
         wait_ar(seen);
         n_checks++;
         if (!seen) begin
            n_fail++;
            $display("FAIL rr_ar_timeout: txn %0d got no ARVALID_S, expected one within 16 cycles", k);
            return;
         end
         ea = ar_q.pop_front();
         n_checks++;
         if (arid_s !== ea.id || araddr_s !== ea.addr || arlen_s !== ea.len || arready_m !== onehot(ea.m)) begin
            n_fail++;
            $display("FAIL rr_grant: txn %0d got id=%h addr=%h len=%0d arready_m=%b, expected id=%h addr=%h len=%0d arready_m=%b",
                     k, arid_s, araddr_s, arlen_s, arready_m, ea.id, ea.addr, ea.len, onehot(ea.m));
         end
         ar_done(ea.m);
         beat(ea.m, ea.id[ID_W-1:0], 1'b1, 3'b111);
         er = r_q.pop_front();
         n_checks++;
         if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || rid_m[er.m] !== er.rid ||
             rlast_m !== er.last || rready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_beat: txn %0d got rvalid_m=%b data=%h rid=%h rready_s=%b, expected rvalid_m=%b data=%h rid=%h rready_s=1",
                     k, rvalid_m, rdata_m, rid_m[er.m], rready_s, onehot(er.m), er.data, er.rid);
         end
      end
   endtask

   task automatic test_stall();
      bit seen; ar_exp_t ea; r_exp_t er;
      @(negedge aclk);
      request(1, 4'h9, 32'h0000_8000, 4'd3);
      wait_ar(seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL stall_ar_timeout: got no ARVALID_S, expected one within 16 cycles");
         return;
      end
      ea = ar_q.pop_front();
      n_checks++;
      if (arid_s !== ea.id || arlen_s !== ea.len || arready_m !== onehot(ea.m)) begin
         n_fail++;
         $display("FAIL stall_grant: got id=%h len=%0d arready_m=%b, expected id=%h len=%0d arready_m=%b",
                  arid_s, arlen_s, arready_m, ea.id, ea.len, onehot(ea.m));
      end
      ar_done(1);
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            for (int s = 0; s < 2; s++) begin
               beat(1, 4'h9, 1'b0, 3'b101);
               n_checks++;
               if (rvalid_m !== 3'b010 || rready_s !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_hold: cycle %0d got rvalid_m=%b rready_s=%b, expected 010 0", s, rvalid_m, rready_s);
               end
            end
         end
         beat(1, 4'h9, (b == 3), 3'b111);
         er = r_q.pop_front();
         n_checks++;
         if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || rid_m[er.m] !== er.rid ||
             rlast_m !== er.last || rready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_beat: beat %0d got rvalid_m=%b data=%h rid=%h rready_s=%b, expected rvalid_m=%b data=%h rid=%h rready_s=1",
                     b, rvalid_m, rdata_m, rid_m[er.m], rready_s, onehot(er.m), er.data, er.rid);
         end
      end
      // A stray RVALID_S after the burst must not reach any master.
      @(negedge aclk);
      rlast_s = 1'b0; rvalid_s = 1'b1;
      #1;
      n_checks++;
      if (rvalid_m !== 3'b000 || rready_s !== 1'b0 || err_len !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_exit: got rvalid_m=%b rready_s=%b err_len=%b, expected 000 0 0", rvalid_m, rready_s, err_len);
      end
      rvalid_s = 1'b0;
   endtask

   task automatic test_err_len();
      bit seen; ar_exp_t ea; r_exp_t er;
      @(negedge aclk);
      request(0, 4'h4, 32'h0000_9000, 4'd3);
      wait_ar(seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL err_ar_timeout: got no ARVALID_S, expected one within 16 cycles");
         return;
      end
      ea = ar_q.pop_front();
      ar_done(ea.m);
      for (int b = 0; b < 3; b++) begin
         beat(0, 4'h4, (b == 2), 3'b111);
         er = r_q.pop_front();
         n_checks++;
         if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL err_beat: beat %0d got rvalid_m=%b data=%h err_len=%b, expected rvalid_m=%b data=%h err_len=0",
                     b, rvalid_m, rdata_m, err_len, onehot(er.m), er.data);
         end
      end
      @(negedge aclk);
      rvalid_s = 1'b0; rlast_s = 1'b0;
      #1;
      n_checks++;
      if (err_len !== 1'b1 || arvalid_s !== 1'b0 || rready_s !== 1'b0) begin
         n_fail++;
         $display("FAIL err_flag: got err_len=%b arvalid_s=%b rready_s=%b, expected 1 0 0", err_len, arvalid_s, rready_s);
      end
   endtask

   task automatic test_hold();
      bit seen; ar_exp_t ea; r_exp_t er;
      @(negedge aclk);
      request(2, 4'hA, 32'h0000_A000, 4'd1);
      wait_ar(seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL hold_ar_timeout: got no ARVALID_S for M2, expected one within 16 cycles");
         return;
      end
      ea = ar_q.pop_front();
      n_checks++;
      if (arid_s !== ea.id || arready_m !== onehot(ea.m)) begin
         n_fail++;
         $display("FAIL hold_grant_m2: got id=%h arready_m=%b, expected id=%h arready_m=%b",
                  arid_s, arready_m, ea.id, onehot(ea.m));
      end
      ar_done(2);
      request(0, 4'hB, 32'h0000_B000, 4'd0);
      for (int b = 0; b < 2; b++) begin
         beat(2, 4'hA, (b == 1), 3'b111);
         er = r_q.pop_front();
         n_checks++;
         if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || rid_m[er.m] !== er.rid ||
             arready_m !== 3'b000 || arvalid_s !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_beat: beat %0d got rvalid_m=%b data=%h arready_m=%b arvalid_s=%b, expected rvalid_m=%b data=%h arready_m=000 arvalid_s=0",
                     b, rvalid_m, rdata_m, arready_m, arvalid_s, onehot(er.m), er.data);
         end
         if (b == 0) begin
            @(negedge aclk);
            rvalid_s = 1'b0;
            #1;
            n_checks++;
            if (arready_m !== 3'b000 || arvalid_s !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_gap: got arready_m=%b arvalid_s=%b, expected 000 0", arready_m, arvalid_s);
            end
         end
      end
      wait_ar(seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL hold_ar_timeout_m0: got no ARVALID_S for M0, expected one within 16 cycles");
         return;
      end
      ea = ar_q.pop_front();
      n_checks++;
      if (arid_s !== ea.id || araddr_s !== ea.addr || arready_m !== onehot(ea.m)) begin
         n_fail++;
         $display("FAIL hold_grant_m0: got id=%h addr=%h arready_m=%b, expected id=%h addr=%h arready_m=%b",
                  arid_s, araddr_s, arready_m, ea.id, ea.addr, onehot(ea.m));
      end
      ar_done(0);
      beat(0, 4'hB, 1'b1, 3'b111);
      er = r_q.pop_front();
      n_checks++;
      if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || err_len !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_m0_beat: got rvalid_m=%b data=%h err_len=%b, expected rvalid_m=%b data=%h err_len=1 (sticky)",
                  rvalid_m, rdata_m, err_len, onehot(er.m), er.data);
      end
   endtask

   task automatic test_async_reset();
      bit seen; ar_exp_t ea; r_exp_t er;
      @(negedge aclk);
      request(1, 4'h5, 32'h0000_C000, 4'd3);
      wait_ar(seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rst_ar_timeout: got no ARVALID_S, expected one within 16 cycles");
         return;
      end
      ea = ar_q.pop_front();
      ar_done(1);
      beat(1, 4'h5, 1'b0, 3'b111);
      er = r_q.pop_front();
      n_checks++;
      if (rvalid_m !== onehot(er.m) || rdata_m !== er.data) begin
         n_fail++;
         $display("FAIL rst_beat0: got rvalid_m=%b data=%h, expected rvalid_m=%b data=%h",
                  rvalid_m, rdata_m, onehot(er.m), er.data);
      end
      // Beat 1 is on the bus when reset hits, before the next clock edge.
      beat(1, 4'h5, 1'b0, 3'b111);
      #2;
      aresetn = 1'b0;
      #1;
      n_checks++;
      if ({arvalid_s, arready_m, rvalid_m, rready_s, err_len} !== 7'd0) begin
         n_fail++;
         $display("FAIL rst_immediate: got arvalid_s=%b arready_m=%b rvalid_m=%b rready_s=%b err_len=%b, expected all 0",
                  arvalid_s, arready_m, rvalid_m, rready_s, err_len);
      end
      r_q.delete();
      ar_q.delete();
      clear_inputs();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      request(1, 4'h7, 32'h0000_E000, 4'd0);
      request(0, 4'h6, 32'h0000_D000, 4'd0);
      // Pointer back at 2 means M0 must win over M1.
      ea = ar_q.pop_front();
      ar_q.push_back(ea);
      for (int k = 0; k < 2; k++) begin
         wait_ar(seen);
         n_checks++;
         if (!seen) begin
            n_fail++;
            $display("FAIL rst_post_timeout: txn %0d got no ARVALID_S, expected one within 16 cycles", k);
            return;
         end
         ea = ar_q.pop_front();
         n_checks++;
         if (arid_s !== ea.id || araddr_s !== ea.addr || arready_m !== onehot(ea.m)) begin
            n_fail++;
            $display("FAIL rst_post_grant: txn %0d got id=%h addr=%h arready_m=%b, expected id=%h addr=%h arready_m=%b",
                     k, arid_s, araddr_s, arready_m, ea.id, ea.addr, onehot(ea.m));
         end
         ar_done(ea.m);
         beat(ea.m, ea.id[ID_W-1:0], 1'b1, 3'b111);
         er = r_q.pop_front();
         n_checks++;
         if (rvalid_m !== onehot(er.m) || rdata_m !== er.data || rid_m[er.m] !== er.rid) begin
            n_fail++;
            $display("FAIL rst_post_beat: txn %0d got rvalid_m=%b data=%h rid=%h, expected rvalid_m=%b data=%h rid=%h",
                     k, rvalid_m, rdata_m, rid_m[er.m], onehot(er.m), er.data, er.rid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_stall();
      test_err_len();
      test_hold();
      test_async_reset();
      @(negedge aclk);
      rvalid_s = 1'b0;
      n_checks++;
      if (ar_q.size() != 0 || r_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d AR and %0d R entries left, expected 0 0", ar_q.size(), r_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
